// File: rtl/dmem_store_drain_pkg.sv
// ============================================================================
// Module : dmem_store_drain_pkg
// Brief  : Shared widths, write-queue entry type and drain FSM states.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_store_drain_pkg;
  localparam int WORD_SIZE_P = 16;
  localparam int WQ_ENTRY    = 4;

  typedef struct packed {
    logic [WORD_SIZE_P-1:0] addr;
    logic [WORD_SIZE_P-1:0] data;
  } dmem_wq_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } dmem_drain_state_e;
endpackage

`default_nettype wire

// File: rtl/dmem_wq_fwd.sv
// ============================================================================
// Module : dmem_wq_fwd
// Brief  : Youngest-match store-to-load forwarding search over the write queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_wq_fwd
  import dmem_store_drain_pkg::*;
#(
  parameter int WQ_ENTRY = dmem_store_drain_pkg::WQ_ENTRY
) (
  input  dmem_wq_entry_t               i_entries [WQ_ENTRY],
  input  logic [$clog2(WQ_ENTRY)-1:0]  i_head,
  input  logic [$clog2(WQ_ENTRY):0]    i_count,
  input  logic [WORD_SIZE_P-1:0]       i_ld_addr,
  output logic                         o_fwd_valid,
  output logic [WORD_SIZE_P-1:0]       o_fwd_data
);
  localparam int PTR_W = $clog2(WQ_ENTRY);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    o_fwd_valid = 1'b0;
    o_fwd_data  = '0;
    w_idx       = '0;
    for (int i = 0; i < WQ_ENTRY; i++) begin
      w_idx = i_head + PTR_W'(i);
      if ((CNT_W'(i) < i_count) && (i_entries[w_idx].addr == i_ld_addr)) begin
        o_fwd_valid = 1'b1;
        o_fwd_data  = i_entries[w_idx].data;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/dmem_store_drain.sv
// ============================================================================
// Module : dmem_store_drain
// Brief  : In-order committed-store write queue drained over a req/ack port,
//          with load forwarding. DMEM_WRITE_COMBINE_EN merges same-address
//          stores into the youngest entry.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_store_drain
  import dmem_store_drain_pkg::*;
#(
  parameter int WQ_ENTRY = dmem_store_drain_pkg::WQ_ENTRY
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   sb_mem_v_i,
  input  logic [WORD_SIZE_P-1:0] sb_mem_addr_i,
  input  logic [WORD_SIZE_P-1:0] sb_mem_data_i,
  output logic                   dmem_sb_ready_o,
  input  logic [WORD_SIZE_P-1:0] ld_addr_i,
  output logic                   ld_fwd_valid_o,
  output logic [WORD_SIZE_P-1:0] ld_fwd_data_o,
  output logic                   mem_req_v_o,
  output logic [WORD_SIZE_P-1:0] mem_req_addr_o,
  output logic [WORD_SIZE_P-1:0] mem_req_data_o,
  input  logic                   mem_req_ack_i,
  output logic                   wq_empty_o
);
  localparam int PTR_W = $clog2(WQ_ENTRY);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WQ_ENTRY);

  dmem_wq_entry_t    r_entries [WQ_ENTRY];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  dmem_drain_state_e r_state;
  dmem_drain_state_e w_state_nxt;

  logic w_combine;
  logic w_push;
  logic w_alloc;
  logic w_pop;

`ifdef DMEM_WRITE_COMBINE_EN
  logic [PTR_W-1:0] w_tail_last;
  assign w_tail_last = r_tail - PTR_W'(1);
  // The in-flight head must not change under the memory, so a lone entry
  // being requested is never a combine target.
  assign w_combine = (r_count != '0)
                   && (r_entries[w_tail_last].addr == sb_mem_addr_i)
                   && ((r_count > CNT_W'(1)) || (r_state == IDLE));
`else
  assign w_combine = 1'b0;
`endif

  assign dmem_sb_ready_o = (r_count != FULL_CNT) | w_combine;
  assign w_push          = sb_mem_v_i & dmem_sb_ready_o;
  assign w_alloc         = w_push & ~w_combine;
  assign w_pop           = (r_state == REQ) & mem_req_ack_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_count != '0) w_state_nxt = REQ;
      REQ:     if (mem_req_ack_i) w_state_nxt = (r_count > CNT_W'(1)) ? REQ : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < WQ_ENTRY; i++) r_entries[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) begin
        r_entries[r_tail] <= '{addr: sb_mem_addr_i, data: sb_mem_data_i};
        r_tail            <= r_tail + PTR_W'(1);
      end
`ifdef DMEM_WRITE_COMBINE_EN
      if (w_push && w_combine) r_entries[w_tail_last].data <= sb_mem_data_i;
`endif
      if (w_pop) r_head <= r_head + PTR_W'(1);
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign mem_req_v_o    = (r_state == REQ);
  assign mem_req_addr_o = (r_state == REQ) ? r_entries[r_head].addr : '0;
  assign mem_req_data_o = (r_state == REQ) ? r_entries[r_head].data : '0;
  assign wq_empty_o     = (r_count == '0) && (r_state == IDLE);

  dmem_wq_fwd #(
    .WQ_ENTRY (WQ_ENTRY)
  ) u_fwd (
    .i_entries   (r_entries),
    .i_head      (r_head),
    .i_count     (r_count),
    .i_ld_addr   (ld_addr_i),
    .o_fwd_valid (ld_fwd_valid_o),
    .o_fwd_data  (ld_fwd_data_o)
  );

  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (reset_i) !(sb_mem_v_i && !dmem_sb_ready_o)
  );
endmodule

`default_nettype wire
